// File: rtl/serial_demux16.sv
// serial_demux16: receive end of the 16:1 bit-select serialiser.
// Collects an LSB-first serial word into a staging register addressed by a
// select counter and presents the completed word with a one-cycle valid pulse.
module serial_demux16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame,
    input  logic             din,
    output logic [SEL_W-1:0] sele,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             frame_err
);

    // One-hot-free encoding chosen so busy is the state flop itself
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    logic [0:0]       state;
    logic [0:0]       state_n;
    logic [SEL_W-1:0] sele_n;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] stage_n;
    logic [WIDTH-1:0] dout_n;
    logic             dout_valid_n;
    logic             frame_err_n;

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sele       <= '0;
            stage      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            sele       <= sele_n;
            stage      <= stage_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state: frame always restarts a word; last bit completes and returns to IDLE
    always_comb begin
        state_n      = state;
        sele_n       = sele;
        stage_n      = stage;
        dout_n       = dout;
        dout_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (frame) begin
                        stage_n[0] = din;
                        sele_n     = SEL_ONE;
                        state_n    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame) begin
                        // Mid-word frame: drop the partial word and restart at bit 0
                        frame_err_n = 1'b1;
                        stage_n[0]  = din;
                        sele_n      = SEL_ONE;
                    end else begin
                        stage_n[sele] = din;
                        if (sele == SEL_LAST) begin
                            dout_n       = {din, stage[WIDTH-2:0]};
                            dout_valid_n = 1'b1;
                            sele_n       = '0;
                            state_n      = IDLE;
                        end else begin
                            sele_n = sele + SEL_ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    sele_n  = '0;
                end
            endcase
        end
    end

    assign busy = state[0];

endmodule
